// File: rtl/keypad_pkg.sv
// Shared types and helpers for the keypad scan controller: FSM state encoding
// and the key-code width function.
package keypad_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_SCAN     = 3'd1,
    ST_DEBOUNCE = 3'd2,
    ST_HELD     = 3'd3,
    ST_RELEASE  = 3'd4
  } keypad_state_e;

  // Width of key_code; never below one bit so tiny keypads still get a port.
  function automatic int code_width(input int rows, input int cols);
    int n;
    n = rows * cols;
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/keypad_evt_fifo.sv
// Small event FIFO between the scan FSM and the consumer. DEPTH must be a
// power of two so the pointers wrap naturally.
module keypad_evt_fifo #(
  parameter int W     = 4,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push_i,
  input  logic [W-1:0] data_i,
  input  logic         pop_i,
  output logic [W-1:0] data_o,
  output logic         valid_o,
  output logic         drop_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [AW:0]   cnt_q;
  logic          empty, full, pop, push_ok;

  assign empty   = (cnt_q == '0);
  assign full    = (cnt_q == FULL_CNT);
  assign pop     = pop_i && !empty;
  // A pop in the same cycle frees the slot, so a full FIFO can still accept.
  assign push_ok = push_i && (!full || pop);
  assign drop_o  = push_i && full && !pop;
  assign valid_o = !empty;
  assign data_o  = mem_q[rd_q];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (push_ok) begin
        mem_q[wr_q] <= data_i;
        wr_q        <= wr_q + AW'(1);
      end
      if (pop) rd_q <= rd_q + AW'(1);
      cnt_q <= cnt_q + (AW+1)'(push_ok) - (AW+1)'(pop);
    end
  end

endmodule

// File: rtl/keypad_scan_ctrl.sv
// Matrix keypad scanner with per-tick debounce and a valid/ready event output.
// Define KEYPAD_SCAN_CTRL_FIFO_EN to buffer events in a 4-entry FIFO.
module keypad_scan_ctrl
  import keypad_pkg::*;
#(
  parameter int ROWS     = 4,
  parameter int COLS     = 4,
  parameter int TICK_DIV = 50000,
  parameter int DEBOUNCE = 3,
  localparam int CW      = code_width(ROWS, COLS)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [ROWS-1:0] row_n,
  output logic [COLS-1:0] col_n,
  output logic [CW-1:0]   key_code,
  output logic            key_valid,
  input  logic            key_ready,
  output logic            key_held,
  output logic            overflow,
  input  logic            ovf_clr,
  output keypad_state_e   dbg_state_o
);

  // Event handshake: an event is transferred on any rising clk edge where
  // key_valid && key_ready; key_valid/key_code hold steady until then.

  localparam int DIV_W = $clog2(TICK_DIV);
  localparam int CI_W  = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int RI_W  = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int CNT_W = $clog2(DEBOUNCE + 1);

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);
  localparam logic [CI_W-1:0]  COL_LAST = CI_W'(COLS - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE - 1);

  logic [ROWS-1:0]  row_meta_q, row_s_q;
  logic [DIV_W-1:0] div_q;
  logic             tick;
  keypad_state_e    state_q, state_d;
  logic [CI_W-1:0]  col_idx_q, col_idx_d;
  logic [RI_W-1:0]  row_idx_q, row_idx_d, low_row;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             any_row, row_hi;
  logic             evt_push, evt_drop;
  logic [CW-1:0]    evt_code;
  logic             ovf_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      row_meta_q <= '1;
      row_s_q    <= '1;
    end else begin
      row_meta_q <= row_n;
      row_s_q    <= row_meta_q;
    end
  end

  assign tick = (div_q == DIV_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) div_q <= '0;
    else     div_q <= tick ? '0 : div_q + DIV_W'(1);
  end

  // Lowest active row wins when several rows share the driven column.
  always_comb begin
    low_row = '0;
    for (int i = ROWS - 1; i >= 0; i--) begin
      if (!row_s_q[i]) low_row = RI_W'(i);
    end
  end

  assign any_row  = (row_s_q != '1);
  assign row_hi   = row_s_q[row_idx_q];
  assign evt_code = CW'(row_idx_q) * CW'(COLS) + CW'(col_idx_q);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      col_idx_q <= '0;
      row_idx_q <= '0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      col_idx_q <= col_idx_d;
      row_idx_q <= row_idx_d;
      cnt_q     <= cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    col_idx_d = col_idx_q;
    row_idx_d = row_idx_q;
    cnt_d     = cnt_q;
    evt_push  = 1'b0;
    if (tick) begin
      unique case (state_q)
        ST_IDLE: begin
          if (any_row) begin
            state_d   = ST_SCAN;
            col_idx_d = '0;
          end
        end
        ST_SCAN: begin
          if (any_row) begin
            row_idx_d = low_row;
            cnt_d     = CNT_W'(1);
            state_d   = ST_DEBOUNCE;
          end else if (col_idx_q == COL_LAST) begin
            col_idx_d = '0;
            state_d   = ST_IDLE;
          end else begin
            col_idx_d = col_idx_q + CI_W'(1);
          end
        end
        ST_DEBOUNCE: begin
          if (row_hi) begin
            cnt_d   = '0;
            state_d = ST_IDLE;
          end else if (cnt_q >= CNT_LAST) begin
            cnt_d    = '0;
            evt_push = 1'b1;
            state_d  = ST_HELD;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        ST_HELD: begin
          if (row_hi) begin
            cnt_d   = CNT_W'(1);
            state_d = ST_RELEASE;
          end
        end
        ST_RELEASE: begin
          if (!row_hi) begin
            cnt_d   = '0;
            state_d = ST_HELD;
          end else if (cnt_q >= CNT_LAST) begin
            cnt_d   = '0;
            state_d = ST_IDLE;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // All columns low in IDLE so any press shows up; otherwise only the scanned one.
  always_comb begin
    col_n = '0;
    if (state_q != ST_IDLE) begin
      col_n            = '1;
      col_n[col_idx_q] = 1'b0;
    end
  end

  assign key_held    = (state_q == ST_HELD) || (state_q == ST_RELEASE);
  assign dbg_state_o = state_q;

`ifdef KEYPAD_SCAN_CTRL_FIFO_EN
  keypad_evt_fifo #(
    .W     (CW),
    .DEPTH (4)
  ) u_evt_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (evt_push),
    .data_i  (evt_code),
    .pop_i   (key_ready),
    .data_o  (key_code),
    .valid_o (key_valid),
    .drop_o  (evt_drop)
  );
`else
  logic [CW-1:0] code_q, code_d;
  logic          valid_q, valid_d;

  always_comb begin
    code_d   = code_q;
    valid_d  = valid_q;
    evt_drop = 1'b0;
    if (evt_push) begin
      if (!valid_q || key_ready) begin
        code_d  = evt_code;
        valid_d = 1'b1;
      end else begin
        evt_drop = 1'b1;
      end
    end else if (valid_q && key_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      code_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      code_q  <= code_d;
      valid_q <= valid_d;
    end
  end

  assign key_code  = code_q;
  assign key_valid = valid_q;
`endif

  // A drop in the same cycle as ovf_clr wins, so no overflow is ever lost.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) ovf_q <= 1'b0;
    else     ovf_q <= (ovf_q & ~ovf_clr) | evt_drop;
  end

  assign overflow = ovf_q;

endmodule

// File: tb/tb_keypad_scan_ctrl.sv
// Bench for keypad_scan_ctrl: a physical key-matrix model feeds row_n from
// col_n, and an expected-event queue models the output buffer capacity.
module tb_keypad_scan_ctrl;
  import keypad_pkg::*;

  localparam int ROWS = 4;
  localparam int COLS = 4;
`ifdef KEYPAD_SCAN_CTRL_FIFO_EN
  localparam int CAP = 4;
`else
  localparam int CAP = 1;
`endif

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [ROWS-1:0] row_n;
  logic [COLS-1:0] col_n;
  logic [3:0]      key_code;
  logic            key_valid;
  logic            key_ready = 1'b0;
  logic            key_held;
  logic            overflow;
  logic            ovf_clr = 1'b0;
  keypad_state_e   dbg_state;

  logic [15:0]     pressed = '0;
  logic [3:0]      exp_q[$];
  logic            exp_ovf = 1'b0;
  int              n_checks = 0;
  int              n_fail = 0;

  keypad_scan_ctrl #(
    .ROWS(ROWS), .COLS(COLS), .TICK_DIV(4), .DEBOUNCE(2)
  ) dut (
    .clk(clk), .rst(rst), .row_n(row_n), .col_n(col_n),
    .key_code(key_code), .key_valid(key_valid), .key_ready(key_ready),
    .key_held(key_held), .overflow(overflow), .ovf_clr(ovf_clr),
    .dbg_state_o(dbg_state)
  );

  always #5 clk = ~clk;

  // Switch matrix: a closed key pulls its row low while its column is driven low.
  always_comb begin
    for (int r = 0; r < ROWS; r++) begin
      row_n[r] = 1'b1;
      for (int c = 0; c < COLS; c++)
        if (pressed[r*COLS+c] && !col_n[c]) row_n[r] = 1'b0;
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press_code(input int code);
    pressed = '0;
    pressed[code] = 1'b1;
  endtask

  task automatic model_event(input logic [3:0] code);
    if (exp_q.size() < CAP) exp_q.push_back(code);
    else exp_ovf = 1'b1;
  endtask

  task automatic wait_valid(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (key_valid === 1'b1) begin ok = 1'b1; break; end
      @(negedge clk);
    end
  endtask

  task automatic wait_st(input keypad_state_e st, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (dbg_state === st) begin ok = 1'b1; break; end
      @(negedge clk);
    end
  endtask

  task automatic wait_unheld(input int budget, output int n, output bit ok);
    ok = 1'b0;
    n = 0;
    for (int i = 0; i < budget; i++) begin
      if (key_held === 1'b0) begin ok = 1'b1; break; end
      @(negedge clk);
      n++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    cyc(3);
    n_checks++; if (col_n !== 4'b0000) begin n_fail++; $display("FAIL reset_col_n: got %b want 0000", col_n); end
    n_checks++; if (key_code !== 4'd0) begin n_fail++; $display("FAIL reset_code: got %0d want 0", key_code); end
    n_checks++; if (key_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", key_valid); end
    n_checks++; if (key_held !== 1'b0) begin n_fail++; $display("FAIL reset_held: got %b want 0", key_held); end
    n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL reset_ovf: got %b want 0", overflow); end
    rst = 1'b0;
    cyc(6);
    n_checks++; if (dbg_state !== ST_IDLE) begin n_fail++; $display("FAIL reset_idle: got %0d want IDLE", dbg_state); end
    n_checks++; if (col_n !== 4'b0000) begin n_fail++; $display("FAIL idle_col_n: got %b want 0000", col_n); end
  endtask

  task automatic test_press_hold();
    bit ok;
    int n;
    key_ready = 1'b0;
    press_code(1*COLS + 2);
    model_event(4'(1*COLS + 2));
    wait_valid(150, ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL hold_valid_timeout: got no key_valid want 1"); end
    n_checks++; if (key_code !== exp_q[0]) begin n_fail++; $display("FAIL hold_code: got %0d want %0d", key_code, exp_q[0]); end
    n_checks++; if (key_held !== 1'b1) begin n_fail++; $display("FAIL hold_held: got %b want 1", key_held); end
    cyc(40);
    n_checks++; if (key_valid !== 1'b1 || key_code !== exp_q[0]) begin n_fail++; $display("FAIL hold_stable: got v=%b code=%0d want v=1 code=%0d", key_valid, key_code, exp_q[0]); end
    key_ready = 1'b1;
    void'(exp_q.pop_front());
    @(negedge clk);
    key_ready = 1'b0;
    n_checks++; if (key_valid !== 1'b0) begin n_fail++; $display("FAIL hold_consumed: got %b want 0", key_valid); end
    pressed = '0;
    wait_unheld(40, n, ok);
    // Two release ticks after a 2-cycle synchroniser: 7..10 cycles.
    n_checks++; if (!ok || n < 7 || n > 10) begin n_fail++; $display("FAIL release_time: got %0d cycles want 7..10", n); end
    cyc(20);
    n_checks++; if (key_valid !== 1'b0) begin n_fail++; $display("FAIL release_no_event: got %b want 0", key_valid); end
  endtask

  task automatic test_bounce();
    bit ok;
    press_code(2*COLS + 3);
    wait_st(ST_DEBOUNCE, 150, ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL bounce_reach: got state %0d want DEBOUNCE", dbg_state); end
    pressed = '0;
    cyc(20);
    n_checks++; if (key_valid !== 1'b0) begin n_fail++; $display("FAIL bounce_valid: got %b want 0", key_valid); end
    n_checks++; if (dbg_state !== ST_IDLE) begin n_fail++; $display("FAIL bounce_state: got %0d want IDLE", dbg_state); end
    n_checks++; if (col_n !== 4'b0000) begin n_fail++; $display("FAIL bounce_col_n: got %b want 0000", col_n); end
  endtask

  task automatic test_multi_row();
    bit ok;
    int n;
    pressed = '0;
    pressed[0*COLS+1] = 1'b1;
    pressed[3*COLS+1] = 1'b1;
    model_event(4'd1);
    wait_valid(150, ok);
    n_checks++; if (!ok || key_code !== exp_q[0]) begin n_fail++; $display("FAIL multi_row_code: got %0d want %0d", key_code, exp_q[0]); end
    key_ready = 1'b1;
    void'(exp_q.pop_front());
    @(negedge clk);
    key_ready = 1'b0;
    pressed = '0;
    wait_unheld(40, n, ok);
    n_checks++; if (!ok || key_valid !== 1'b0) begin n_fail++; $display("FAIL multi_row_release: got held=%b v=%b want 0 0", key_held, key_valid); end
  endtask

  task automatic test_overflow();
    bit ok;
    int n;
    int codes[5] = '{6, 9, 1, 14, 3};
    key_ready = 1'b0;
    for (int i = 0; i < CAP + 1; i++) begin
      press_code(codes[i]);
      wait_st(ST_HELD, 150, ok);
      n_checks++; if (!ok) begin n_fail++; $display("FAIL ovf_press_%0d: got state %0d want HELD", i, dbg_state); end
      model_event(4'(codes[i]));
      pressed = '0;
      wait_unheld(40, n, ok);
    end
    n_checks++; if (overflow !== exp_ovf) begin n_fail++; $display("FAIL ovf_set: got %b want %b", overflow, exp_ovf); end
    n_checks++; if (key_valid !== 1'b1 || key_code !== exp_q[0]) begin n_fail++; $display("FAIL ovf_head: got v=%b code=%0d want v=1 code=%0d", key_valid, key_code, exp_q[0]); end
    ovf_clr = 1'b1;
    @(negedge clk);
    ovf_clr = 1'b0;
    exp_ovf = 1'b0;
    n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL ovf_clear: got %b want 0", overflow); end
    key_ready = 1'b1;
    while (exp_q.size() > 0) begin
      logic [3:0] e;
      e = exp_q.pop_front();
      n_checks++; if (key_valid !== 1'b1 || key_code !== e) begin n_fail++; $display("FAIL ovf_drain: got v=%b code=%0d want v=1 code=%0d", key_valid, key_code, e); end
      @(negedge clk);
    end
    key_ready = 1'b0;
    n_checks++; if (key_valid !== 1'b0) begin n_fail++; $display("FAIL ovf_empty: got %b want 0", key_valid); end
  endtask

  task automatic test_back_to_back();
    bit ok;
    int n;
    int codes[4] = '{6, 9, 1, 14};
    logic [3:0] e;
    key_ready = 1'b0;
    for (int i = 0; i < CAP; i++) begin
      press_code(codes[i]);
      wait_st(ST_HELD, 150, ok);
      model_event(4'(codes[i]));
      pressed = '0;
      wait_unheld(40, n, ok);
    end
    press_code(2*COLS + 3);
    wait_st(ST_DEBOUNCE, 150, ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL b2b_reach: got state %0d want DEBOUNCE", dbg_state); end
    ok = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (dut.tick === 1'b1) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    // Consume the head on exactly the cycle the new event is pushed.
    key_ready = 1'b1;
    e = exp_q.pop_front();
    n_checks++; if (key_code !== e) begin n_fail++; $display("FAIL b2b_head: got %0d want %0d", key_code, e); end
    @(negedge clk);
    key_ready = 1'b0;
    model_event(4'(2*COLS + 3));
    n_checks++; if (overflow !== 1'b0 || exp_ovf !== 1'b0) begin n_fail++; $display("FAIL b2b_ovf: got %b want 0", overflow); end
    n_checks++; if (key_valid !== 1'b1 || key_code !== exp_q[0]) begin n_fail++; $display("FAIL b2b_new: got v=%b code=%0d want v=1 code=%0d", key_valid, key_code, exp_q[0]); end
    pressed = '0;
    wait_unheld(40, n, ok);
    key_ready = 1'b1;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_checks++; if (key_valid !== 1'b1 || key_code !== e) begin n_fail++; $display("FAIL b2b_order: got v=%b code=%0d want v=1 code=%0d", key_valid, key_code, e); end
      @(negedge clk);
    end
    key_ready = 1'b0;
    n_checks++; if (key_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_empty: got %b want 0", key_valid); end
  endtask

  task automatic test_reset_mid_debounce();
    bit ok;
    int n;
    key_ready = 1'b0;
    press_code(1*COLS + 1);
    wait_st(ST_HELD, 150, ok);
    model_event(4'(1*COLS + 1));
    pressed = '0;
    wait_unheld(40, n, ok);
    press_code(2*COLS + 2);
    wait_st(ST_DEBOUNCE, 150, ok);
    n_checks++; if (!ok || key_valid !== 1'b1) begin n_fail++; $display("FAIL rstmid_pre: got state=%0d v=%b want DEBOUNCE v=1", dbg_state, key_valid); end
    rst = 1'b1;
    #1;
    exp_q.delete();
    exp_ovf = 1'b0;
    n_checks++; if (key_valid !== 1'b0) begin n_fail++; $display("FAIL rstmid_valid: got %b want 0", key_valid); end
    n_checks++; if (key_code !== 4'd0) begin n_fail++; $display("FAIL rstmid_code: got %0d want 0", key_code); end
    n_checks++; if (col_n !== 4'b0000) begin n_fail++; $display("FAIL rstmid_col_n: got %b want 0000", col_n); end
    n_checks++; if (key_held !== 1'b0) begin n_fail++; $display("FAIL rstmid_held: got %b want 0", key_held); end
    n_checks++; if (dbg_state !== ST_IDLE) begin n_fail++; $display("FAIL rstmid_state: got %0d want IDLE", dbg_state); end
    pressed = '0;
    cyc(3);
    rst = 1'b0;
    cyc(60);
    n_checks++; if (key_valid !== 1'b0 || key_held !== 1'b0) begin n_fail++; $display("FAIL rstmid_after: got v=%b held=%b want 0 0", key_valid, key_held); end
  endtask

  task automatic test_random();
    bit ok;
    int n, col, mask, lo;
    logic [3:0] e;
    for (int it = 0; it < 10; it++) begin
      col = $urandom_range(0, COLS - 1);
      mask = $urandom_range(1, (1 << ROWS) - 1);
      pressed = '0;
      lo = -1;
      for (int r = ROWS - 1; r >= 0; r--)
        if (mask[r]) begin pressed[r*COLS+col] = 1'b1; lo = r; end
      model_event(4'(lo*COLS + col));
      wait_valid(150, ok);
      n_checks++; if (!ok) begin n_fail++; $display("FAIL rand_timeout_%0d: got no key_valid want 1", it); end
      cyc($urandom_range(0, 5));
      key_ready = 1'b1;
      e = exp_q.pop_front();
      n_checks++; if (key_code !== e) begin n_fail++; $display("FAIL rand_code_%0d: got %0d want %0d", it, key_code, e); end
      n_checks++; if (key_held !== 1'b1) begin n_fail++; $display("FAIL rand_held_%0d: got %b want 1", it, key_held); end
      @(negedge clk);
      key_ready = 1'b0;
      pressed = '0;
      wait_unheld(40, n, ok);
      n_checks++; if (!ok || key_valid !== 1'b0) begin n_fail++; $display("FAIL rand_release_%0d: got held=%b v=%b want 0 0", it, key_held, key_valid); end
      cyc($urandom_range(0, 8));
    end
  endtask

  initial begin
    #400us;
    n_fail++;
    $display("FAIL watchdog: got timeout want test completion");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_press_hold();
    test_bounce();
    test_multi_row();
    test_overflow();
    test_back_to_back();
    test_reset_mid_debounce();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/keypad_scan_ctrl.md
KEYPAD_SCAN_CTRL -- requirements
Module: keypad_scan_ctrl

Interface
REQ-001 SHALL have parameter ROWS, default 4: number of keypad rows (2..8).
REQ-002 SHALL have parameter COLS, default 4: number of keypad columns (2..8).
REQ-003 SHALL have parameter TICK_DIV, default 50000: clk cycles per scan tick (>=2).
REQ-004 SHALL have parameter DEBOUNCE, default 3: consecutive stable ticks required for press and for release (>=1).
REQ-005 SHALL have port clk, input, 1: system clock; all logic is on its rising edge.
REQ-006 SHALL have port rst, input, 1: reset, asynchronous, active-high.
REQ-007 SHALL have port row_n, input, ROWS: keypad row sense lines, active-low, asynchronous to clk.
REQ-008 SHALL have port col_n, output, COLS: column drive lines, active-low.
REQ-009 SHALL have port key_code, output, CW = clog2(ROWS*COLS): code = row_idx*COLS + col_idx.
REQ-010 SHALL have port key_valid, output, 1: key_code holds an unconsumed event.
REQ-011 SHALL have port key_ready, input, 1: consumer accepts the event when key_valid && key_ready.
REQ-012 SHALL have port key_held, output, 1: a debounced key is currently down.
REQ-013 SHALL have port overflow, output, 1: sticky flag, an event was dropped.
REQ-014 SHALL have port ovf_clr, input, 1: single-cycle clear of overflow.

Function
REQ-015 SHALL pass row_n through a 2-FF synchroniser; all row decisions use the synchronised value (row_s).
REQ-016 SHALL generate a 1-clk tick when the divider counter equals TICK_DIV-1, then wrap it to 0; FSM and debounce act only on tick cycles.
REQ-017 SHALL implement states IDLE, SCAN, DEBOUNCE, HELD, RELEASE.
REQ-018 IDLE: col_n all 0; on a tick with row_s != all-ones, go to SCAN with col index 0.
REQ-019 SCAN: drive only column idx low. On a tick with row_s != all-ones, latch idx and the lowest active row, then go to DEBOUNCE with count 1. Otherwise increment idx; after COLS-1 return to IDLE.
REQ-020 DEBOUNCE: keep the column driven. On a tick with the latched row still low, increment count; at count == DEBOUNCE, go to HELD and emit the event. On a tick with the latched row high, return to IDLE with no event.
REQ-021 HELD: key_held=1. On a tick with the latched row high, go to RELEASE with count 1.
REQ-022 RELEASE: key_held=1. On a tick with the row high, increment count; at count == DEBOUNCE, go to IDLE. On a tick with the row low, return to HELD.
REQ-023 The event SHALL appear on key_valid/key_code on the clk cycle after the deciding tick.
REQ-024 Without the FIFO: a single output register; key_valid stays 1 and key_code stays stable until handshake. An event arriving while key_valid && !key_ready SHALL be dropped and set overflow. A handshake and a new event in the same cycle SHALL load the new event with no overflow.
REQ-025 When ovf_clr and a new overflow occur in the same cycle, overflow SHALL be 1.
REQ-026 When several rows are active in one column, the lowest row index SHALL be used; other columns are ignored until IDLE.

Reset
REQ-027 Reset SHALL force: state IDLE, col_n all 0, key_code 0, key_valid 0, key_held 0, overflow 0, divider and debounce counts 0, synchroniser all-ones, FIFO empty.
REQ-028 Reset mid-DEBOUNCE or mid-HELD SHALL discard the pending key; no event is emitted after release.

Configuration
REQ-029 Macro KEYPAD_SCAN_CTRL_FIFO_EN defined SHALL build a 4-entry event FIFO; key_valid = !empty and key_code = head entry.
REQ-030 With the FIFO, a push when full SHALL be dropped and set overflow. A simultaneous push and pop when full SHALL be accepted with no overflow. A push when empty SHALL appear next cycle.
REQ-031 Macro undefined SHALL give the single-register behaviour of REQ-024.

Structure
REQ-032 Package keypad_pkg SHALL hold the FSM state enum and the code-width function/constant.
REQ-033 The FIFO SHALL be sub-module keypad_evt_fifo, instantiated only under KEYPAD_SCAN_CTRL_FIFO_EN.

Verification (ROWS=COLS=4, TICK_DIV=4, DEBOUNCE=2)
REQ-034 Row1/col2 pressed and held, key_ready=0 -> key_code=6, key_valid=1 stays until key_ready=1, then 0; key_held=1 until 2 release ticks.
REQ-035 Press bounces high after 1 tick in DEBOUNCE -> no key_valid, FSM back to IDLE, col_n=0000.
REQ-036 No FIFO: keys 6 then 9 pressed, key_ready=0 -> key_code=6, overflow=1; ovf_clr -> overflow=0.
REQ-037 FIFO: 5 events, key_ready=0 -> 4 retained in order, overflow=1. Full FIFO with simultaneous push and pop -> no overflow, order kept.
REQ-038 Rows 0 and 3 in col 1 together -> key_code=1.
REQ-039 rst asserted mid-DEBOUNCE -> outputs at reset values immediately; no event after rst deasserts.
